// File: rtl/csa_mul_if.sv
// Operand/result handshake bundle for csa_mul_seq.
// CSA_MUL_ACC_EN adds the acc_clr operand-side signal.
interface csa_mul_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned RW    = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef CSA_MUL_ACC_EN
    logic             acc_clr;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [RW-1:0]    result;
    logic             busy;

    modport master (
        output in_valid, a, b,
`ifdef CSA_MUL_ACC_EN
        output acc_clr,
`endif
        output out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, a, b,
`ifdef CSA_MUL_ACC_EN
        input  acc_clr,
`endif
        input  out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/csa_mul_seq.sv
// Iterative unsigned multiplier: one multiplier bit per cycle into a carry-save pair,
// then one carry-propagate add. Define CSA_MUL_ACC_EN for multiply-accumulate mode.
module csa_mul_seq #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned ACC_GUARD = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    csa_mul_if.slave  bus
);
`ifdef CSA_MUL_ACC_EN
    localparam int unsigned RW = 2 * WIDTH + ACC_GUARD;
`else
    localparam int unsigned RW = 2 * WIDTH;
`endif
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (WIDTH < 2 || WIDTH > 16 || ACC_GUARD > 32) begin : g_bad_params
        $error("csa_mul_seq: WIDTH must be 2..16 and ACC_GUARD at most 32");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_RESOLVE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RW-1:0]    sum_q, sum_d;
    logic [RW-1:0]    carry_q, carry_d;
    logic [RW-1:0]    result_q, result_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [RW-1:0]    pp_c;
    logic [RW-1:0]    carry_sh_c;
    logic [RW-1:0]    preload_c;

    // Accumulate mode seeds the redundant pair with the previous result.
`ifdef CSA_MUL_ACC_EN
    assign preload_c = bus.acc_clr ? '0 : result_q;
`else
    assign preload_c = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            carry_q     <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        cnt_d      = cnt_q;
        sum_d      = sum_q;
        carry_d    = carry_q;
        result_d   = result_q;
        pp_c       = b_q[cnt_q] ? (RW'(a_q) << cnt_q) : '0;
        carry_sh_c = carry_q << 1;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    state_d = S_RUN;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    cnt_d   = '0;
                    sum_d   = preload_c;
                    carry_d = '0;
                end
            end
            S_RUN: begin
                // One 3:2 row: sum + (carry<<1) + pp preserved as new sum + (new carry<<1).
                sum_d   = sum_q ^ carry_sh_c ^ pp_c;
                carry_d = (sum_q & carry_sh_c) | (sum_q & pp_c) | (carry_sh_c & pp_c);
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_RESOLVE;
                end
            end
            S_RESOLVE: begin
                result_d = sum_q + carry_sh_c;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d == S_RUN) || (state_d == S_RESOLVE);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.result    = result_q;
endmodule

// File: doc/csa_mul_seq.md
Name: csa_mul_seq

Overview:
- Parametrised, iterative unsigned multiplier built on a registered carry-save (3:2) accumulator.
- Each cycle it retires one multiplier bit into a redundant sum/carry pair. A single carry-propagate add then resolves the pair into the product.
- Sits behind the UART/SPI command decoder as the multiply engine. It replaces fixed-width combinational carry-save trees with one width-configurable, handshaked block.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..16.
- ACC_GUARD, 4, extra accumulator MSBs. Used only when CSA_MUL_ACC_EN is defined.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset; deassertion synchronous to clk externally.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- acc_clr  input  1  present only with CSA_MUL_ACC_EN; clears the accumulator on accept.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- result  output  RW  product. RW = 2*WIDTH, or 2*WIDTH+ACC_GUARD with CSA_MUL_ACC_EN.
- busy  output  1  high in RUN or RESOLVE.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, busy=0, result=0.
  - Sum/carry registers, bit counter and operand registers all cleared.
- States: IDLE, RUN, RESOLVE, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: register a and b, clear the bit counter, preload the sum/carry pair (0, or see Optional Feature), go to RUN.
- RUN:
  - One cycle per multiplier bit, LSB first; exactly WIDTH cycles.
  - Cycle i: partial product = (b[i] ? a : 0) << i.
  - Compress (sum, carry<<1, partial product) with one bitwise 3:2 full-adder row into the new sum and carry, truncated to RW bits.
  - Counter increments. After counter reaches WIDTH-1, go to RESOLVE.
- RESOLVE:
  - One cycle; result <= sum + (carry<<1), modulo 2^RW.
  - Go to DONE.
- DONE:
  - out_valid=1; result held stable.
  - On out_ready=1, go to IDLE and drop out_valid on the same edge.
  - out_ready may already be high when out_valid rises; the handshake then completes in 1 cycle.
- Latency:
  - out_valid rises WIDTH+1 clock edges after the accept edge.
  - Accept-to-next-accept is at least WIDTH+3 cycles.
- in_valid outside IDLE is ignored; operands are not queued.
- a, b and acc_clr are sampled only on the accept edge. Later changes have no effect.
- result retains its last value after leaving DONE until the next RESOLVE.
- Zero operand: still runs the full WIDTH cycles; result=0 (plus the accumulator value in accumulate mode).
- Reset mid-RUN/RESOLVE/DONE: operation is abandoned, no out_valid is produced, all outputs take their reset values.
- No X propagation: every register is reset.

Optional Feature:
- Macro CSA_MUL_ACC_EN.
- Defined:
  - Block is a multiply-accumulate unit; result width is 2*WIDTH+ACC_GUARD; acc_clr port exists.
  - On accept, the sum register is preloaded with the current result, and the carry register is cleared.
  - If acc_clr=1 on the accept edge, the preload is 0.
  - The accumulated value wraps modulo 2^RW with no saturation and no overflow flag.
- Undefined:
  - acc_clr port is absent and ACC_GUARD is unused.
  - Preload is always 0 and result width is 2*WIDTH.

Test Plan:
- WIDTH=4: a=15, b=15, out_ready=1 -> result=225; out_valid high exactly 5 edges after accept for 1 cycle; in_ready low for the whole operation.
- WIDTH=4: a=9, b=6, out_ready held 0 for 10 cycles -> result=54 stable, out_valid held; second in_valid during DONE ignored; release out_ready -> IDLE next edge.
- WIDTH=4: accept a=13, b=11; assert rst_n=0 on RUN cycle 2 -> all outputs at reset values immediately; no out_valid afterwards; next op a=3, b=3 -> 9.
- WIDTH=8: a=255, b=255 -> 65025. a=0, b=200 -> 0 after 9 edges. a=1, b=128 -> 128.
- CSA_MUL_ACC_EN, WIDTH=4, ACC_GUARD=4:
  - 3*5 with acc_clr=1 -> 15.
  - Then 2*7 with acc_clr=0 -> 29.
  - Then 0*0 with acc_clr=1 -> 0.
- CSA_MUL_ACC_EN, WIDTH=4, ACC_GUARD=4, wrap check:
  - 19 back-to-back 15*15, first with acc_clr=1 -> after the 18th result=4050; after the 19th result=179 (4275 mod 4096).
